// File: rtl/sp2ins_decoder_pkg.sv
// sp2ins_decoder_pkg
// Definitions shared by the spike-to-instruction decoder and the matching
// ins2sp encoder:
//   - frame header bit offsets, relative to the payload width N
//       [N+10] sof, [N+9] eof, [N+8:N+6] field id, [N+5:N] chunk index
//   - field id constants
//   - FSM state encoding
// Related build option: SP2INS_ERRCNT_EN (see sp2ins_decoder.sv).
package sp2ins_decoder_pkg;

  localparam int HDR_W         = 11;
  localparam int SOF_OFS       = 10;
  localparam int EOF_OFS       = 9;
  localparam int FID_MSB_OFS   = 8;
  localparam int FID_LSB_OFS   = 6;
  localparam int CHUNK_MSB_OFS = 5;
  localparam int CHUNK_LSB_OFS = 0;

  localparam int FID_W      = FID_MSB_OFS - FID_LSB_OFS + 1;
  localparam int CHUNK_W    = CHUNK_MSB_OFS - CHUNK_LSB_OFS + 1;
  localparam int NUM_FIELDS = 6;

  localparam logic [FID_W-1:0] FID_RS1   = 3'd0;
  localparam logic [FID_W-1:0] FID_RS2   = 3'd1;
  localparam logic [FID_W-1:0] FID_RDIDX = 3'd2;
  localparam logic [FID_W-1:0] FID_INFO  = 3'd3;
  localparam logic [FID_W-1:0] FID_PC    = 3'd4;
  localparam logic [FID_W-1:0] FID_IMM   = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Ids 6 and 7 do not name a field.
  function automatic logic fid_legal(input logic [FID_W-1:0] fid);
    return fid <= FID_IMM;
  endfunction

endpackage

// File: rtl/sp2ins_decoder_if.sv
// sp2ins_decoder_if
// Bundles the spike-frame input stream and the operand-record output of the
// decoder.
//   slave  : the decoder (accepts frames, presents records)
//   master : the environment (sends frames, consumes records)
// Signals:
//   i_sp_valid/i_sp_ready/i_sp         frame stream, i_sp is N+11 bits
//   o_valid/o_ready                    record handshake
//   o_rs1 o_rs2 o_rdidx o_info o_pc o_imm   reassembled fields
//   o_seen                             per-field written mask
//   o_err                              protocol error pulse
//   o_err_cnt                          saturating error count, present only
//                                      when SP2INS_ERRCNT_EN is defined
interface sp2ins_decoder_if
  import sp2ins_decoder_pkg::*;
#(
  parameter int N           = 8,
  parameter int width_rs    = 32,
  parameter int width_rdidx = 5,
  parameter int width_info  = 32,
  parameter int width_pc    = 32,
  parameter int width_imm   = 32
);

  logic                    i_sp_valid;
  logic                    i_sp_ready;
  logic [N+HDR_W-1:0]      i_sp;
  logic                    o_valid;
  logic                    o_ready;
  logic [width_rs-1:0]     o_rs1;
  logic [width_rs-1:0]     o_rs2;
  logic [width_rdidx-1:0]  o_rdidx;
  logic [width_info-1:0]   o_info;
  logic [width_pc-1:0]     o_pc;
  logic [width_imm-1:0]    o_imm;
  logic [NUM_FIELDS-1:0]   o_seen;
  logic                    o_err;
`ifdef SP2INS_ERRCNT_EN
  logic [7:0]              o_err_cnt;
`endif

  modport slave (
    input  i_sp_valid, i_sp, o_ready,
    output i_sp_ready, o_valid, o_rs1, o_rs2, o_rdidx, o_info, o_pc, o_imm,
           o_seen, o_err
`ifdef SP2INS_ERRCNT_EN
    , output o_err_cnt
`endif
  );

  modport master (
    output i_sp_valid, i_sp, o_ready,
    input  i_sp_ready, o_valid, o_rs1, o_rs2, o_rdidx, o_info, o_pc, o_imm,
           o_seen, o_err
`ifdef SP2INS_ERRCNT_EN
    , input o_err_cnt
`endif
  );

endinterface

// File: rtl/sp2ins_field_reg.sv
// sp2ins_field_reg
// One W-bit operand holding register written N bits at a time.
//   clk, rst  clock, async active-high reset
//   clr       zero the register (a write in the same cycle lands on top)
//   wr_en     write payload into bits [chunk*N +: N]
//   chunk     chunk index
//   payload   N-bit data
//   q         register contents
//   oor       chunk starts at or beyond W; such a write is ignored
module sp2ins_field_reg
  import sp2ins_decoder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic [N-1:0]       payload,
  output logic [W-1:0]       q,
  output logic               oor
);

  logic [31:0]  base;
  logic [W-1:0] data_sh;
  logic [W-1:0] mask_sh;
  logic [W-1:0] q_next;

  assign base = 32'(chunk) * 32'(N);
  assign oor  = base >= 32'(W);

  // Shifting inside a W-bit vector drops payload bits past the field top.
  assign data_sh = W'(payload) << base;
  assign mask_sh = W'({N{1'b1}}) << base;

  always_comb begin
    q_next = clr ? '0 : q;
    if (wr_en && !oor) begin
      q_next = (q_next & ~mask_sh) | data_sh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/sp2ins_decoder.sv
// sp2ins_decoder
// Receives spike frames and reassembles one dispatched-instruction operand
// record (rs1, rs2, rdidx, info, pc, imm) per sof..eof packet.
//   clk, rst  clock, async active-high reset
//   bus       sp2ins_decoder_if.slave: frame stream in, record out, o_seen,
//             o_err pulse and, when SP2INS_ERRCNT_EN is defined, a
//             saturating 8-bit o_err_cnt
// A record is held in HOLD until taken; no frame is accepted meanwhile.
module sp2ins_decoder
  import sp2ins_decoder_pkg::*;
#(
  parameter int N           = 8,
  parameter int width_rs    = 32,
  parameter int width_rdidx = 5,
  parameter int width_info  = 32,
  parameter int width_pc    = 32,
  parameter int width_imm   = 32
) (
  input logic clk,
  input logic rst,
  sp2ins_decoder_if.slave bus
);

  logic                  sof, eof;
  logic [FID_W-1:0]      fid;
  logic [CHUNK_W-1:0]    chunk;
  logic [N-1:0]          payload;

  state_t                state, state_next;
  logic                  ready_q, valid_q, err_q;
  logic [NUM_FIELDS-1:0] seen_q, oor, wr_en;
  logic                  accept, clr_all, do_write, err_now, sel_oor, fid_ok;

  logic [width_rs-1:0]    rs1_q, rs2_q;
  logic [width_rdidx-1:0] rdidx_q;
  logic [width_info-1:0]  info_q;
  logic [width_pc-1:0]    pc_q;
  logic [width_imm-1:0]   imm_q;

  assign sof     = bus.i_sp[N+SOF_OFS];
  assign eof     = bus.i_sp[N+EOF_OFS];
  assign fid     = bus.i_sp[N+FID_MSB_OFS:N+FID_LSB_OFS];
  assign chunk   = bus.i_sp[N+CHUNK_MSB_OFS:N+CHUNK_LSB_OFS];
  assign payload = bus.i_sp[N-1:0];
  assign accept  = bus.i_sp_valid & ready_q;

  // Frame decode: a sof frame always restarts the record, sof/eof steer the
  // FSM even when the frame's own write is rejected.
  always_comb begin
    state_next = state;
    clr_all    = 1'b0;
    do_write   = 1'b0;
    err_now    = 1'b0;
    fid_ok     = fid_legal(fid);
    sel_oor    = 1'b0;
    wr_en      = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (fid == FID_W'(k)) sel_oor = oor[k];
    end
    case (state)
      IDLE: begin
        if (accept) begin
          if (sof) begin
            clr_all    = 1'b1;
            do_write   = 1'b1;
            err_now    = !fid_ok || sel_oor;
            state_next = eof ? HOLD : COLLECT;
          end else begin
            err_now = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          clr_all    = sof;
          do_write   = 1'b1;
          err_now    = sof || !fid_ok || sel_oor;
          state_next = eof ? HOLD : COLLECT;
        end
      end
      HOLD: begin
        if (bus.o_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    for (int k = 0; k < NUM_FIELDS; k++) begin
      wr_en[k] = do_write && fid_ok && !sel_oor && (fid == FID_W'(k));
    end
  end

  // Ready and valid are registered copies of the next state so neither has a
  // combinational path from the handshake inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != HOLD);
      valid_q <= (state_next == HOLD);
      err_q   <= err_now;
      seen_q  <= (clr_all ? '0 : seen_q) | wr_en;
    end
  end

`ifdef SP2INS_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside o_err and sticks at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_now && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif

  sp2ins_field_reg #(.W(width_rs), .N(N)) u_rs1 (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_RS1]),
    .chunk(chunk), .payload(payload), .q(rs1_q), .oor(oor[FID_RS1])
  );
  sp2ins_field_reg #(.W(width_rs), .N(N)) u_rs2 (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_RS2]),
    .chunk(chunk), .payload(payload), .q(rs2_q), .oor(oor[FID_RS2])
  );
  sp2ins_field_reg #(.W(width_rdidx), .N(N)) u_rdidx (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_RDIDX]),
    .chunk(chunk), .payload(payload), .q(rdidx_q), .oor(oor[FID_RDIDX])
  );
  sp2ins_field_reg #(.W(width_info), .N(N)) u_info (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_INFO]),
    .chunk(chunk), .payload(payload), .q(info_q), .oor(oor[FID_INFO])
  );
  sp2ins_field_reg #(.W(width_pc), .N(N)) u_pc (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_PC]),
    .chunk(chunk), .payload(payload), .q(pc_q), .oor(oor[FID_PC])
  );
  sp2ins_field_reg #(.W(width_imm), .N(N)) u_imm (
    .clk(clk), .rst(rst), .clr(clr_all), .wr_en(wr_en[FID_IMM]),
    .chunk(chunk), .payload(payload), .q(imm_q), .oor(oor[FID_IMM])
  );

  assign bus.i_sp_ready = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_err      = err_q;
  assign bus.o_seen     = seen_q;
  assign bus.o_rs1      = rs1_q;
  assign bus.o_rs2      = rs2_q;
  assign bus.o_rdidx    = rdidx_q;
  assign bus.o_info     = info_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_imm      = imm_q;

endmodule

// File: tb/tb_sp2ins_decoder.sv
// tb_sp2ins_decoder
// Directed test of sp2ins_decoder with N=8 and 32/5/32/32/32-bit fields.
// Build with SP2INS_ERRCNT_EN defined to also check o_err_cnt.
module tb_sp2ins_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sp2ins_decoder_if #(
    .N(8), .width_rs(32), .width_rdidx(5), .width_info(32),
    .width_pc(32), .width_imm(32)
  ) bus ();

  sp2ins_decoder #(
    .N(8), .width_rs(32), .width_rdidx(5), .width_info(32),
    .width_pc(32), .width_imm(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a wedged run still ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one frame and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic sof, input logic eof,
                               input logic [2:0] fid, input logic [5:0] chunk,
                               input logic [7:0] pay);
    int waited;
    waited = 0;
    bus.i_sp       = {sof, eof, fid, chunk, pay};
    bus.i_sp_valid = 1'b1;
    while (!bus.i_sp_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.i_sp_ready) checkOutput("accept_timeout", 64'(bus.i_sp_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.i_sp_valid = 1'b0;
  endtask

  task automatic popRecord();
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    checkOutput("pop_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("pop_ready", 64'(bus.i_sp_ready), 64'd1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.i_sp_valid = 1'b0;
    bus.i_sp       = '0;
    bus.o_ready    = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_ready", 64'(bus.i_sp_ready), 64'd1);
    checkOutput("rst_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("rst_seen", 64'(bus.o_seen), 64'd0);
    checkOutput("rst_err", 64'(bus.o_err), 64'd0);
    checkOutput("rst_rs1", 64'(bus.o_rs1), 64'd0);
    checkOutput("rst_pc", 64'(bus.o_pc), 64'd0);
`ifdef SP2INS_ERRCNT_EN
    checkOutput("rst_errcnt", 64'(bus.o_err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-frame packet into rdidx
    applyStimulus(1'b1, 1'b1, 3'd2, 6'd0, 8'h1F);
    checkOutput("single_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("single_rdidx", 64'(bus.o_rdidx), 64'h1F);
    checkOutput("single_seen", 64'(bus.o_seen), 64'b000100);
    checkOutput("single_rs1", 64'(bus.o_rs1), 64'd0);
    checkOutput("single_rs2", 64'(bus.o_rs2), 64'd0);
    checkOutput("single_info", 64'(bus.o_info), 64'd0);
    checkOutput("single_pc", 64'(bus.o_pc), 64'd0);
    checkOutput("single_imm", 64'(bus.o_imm), 64'd0);
    checkOutput("single_ready", 64'(bus.i_sp_ready), 64'd0);
    checkOutput("single_err", 64'(bus.o_err), 64'd0);
    popRecord();

    // Four-chunk pc
    applyStimulus(1'b1, 1'b0, 3'd4, 6'd0, 8'h78);
    checkOutput("pc_mid_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("pc_mid_seen", 64'(bus.o_seen), 64'b010000);
    applyStimulus(1'b0, 1'b0, 3'd4, 6'd1, 8'h56);
    applyStimulus(1'b0, 1'b0, 3'd4, 6'd2, 8'h34);
    applyStimulus(1'b0, 1'b1, 3'd4, 6'd3, 8'h12);
    checkOutput("pc_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("pc_value", 64'(bus.o_pc), 64'h12345678);
    checkOutput("pc_seen", 64'(bus.o_seen), 64'b010000);
    checkOutput("pc_rdidx", 64'(bus.o_rdidx), 64'd0);

    // Backpressure: a frame waits while the record is held
    bus.i_sp       = {1'b1, 1'b1, 3'd0, 6'd0, 8'h11};
    bus.i_sp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 64'(bus.o_valid), 64'd1);
      checkOutput("bp_pc", 64'(bus.o_pc), 64'h12345678);
      checkOutput("bp_ready", 64'(bus.i_sp_ready), 64'd0);
      checkOutput("bp_seen", 64'(bus.o_seen), 64'b010000);
    end
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    checkOutput("bp_pop_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("bp_pop_ready", 64'(bus.i_sp_ready), 64'd1);
    checkOutput("bp_no_bypass", 64'(bus.o_pc), 64'h12345678);
    @(posedge clk);
    #1;
    bus.i_sp_valid = 1'b0;
    checkOutput("bp_next_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("bp_next_rs1", 64'(bus.o_rs1), 64'h11);
    checkOutput("bp_next_pc", 64'(bus.o_pc), 64'd0);
    checkOutput("bp_next_seen", 64'(bus.o_seen), 64'b000001);
    popRecord();

    // Error: sof=0 in IDLE is dropped
    applyStimulus(1'b0, 1'b0, 3'd0, 6'd0, 8'h55);
    checkOutput("nosof_err", 64'(bus.o_err), 64'd1);
    checkOutput("nosof_ready", 64'(bus.i_sp_ready), 64'd1);
    checkOutput("nosof_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("nosof_rs1", 64'(bus.o_rs1), 64'h11);
    @(posedge clk);
    #1;
    checkOutput("nosof_err_end", 64'(bus.o_err), 64'd0);

    // Error: illegal field id still starts the packet
    applyStimulus(1'b1, 1'b0, 3'd7, 6'd0, 8'h33);
    checkOutput("fid7_err", 64'(bus.o_err), 64'd1);
    checkOutput("fid7_rs1", 64'(bus.o_rs1), 64'd0);
    checkOutput("fid7_seen", 64'(bus.o_seen), 64'd0);
    checkOutput("fid7_valid", 64'(bus.o_valid), 64'd0);

    // rdidx keeps only its 5 low bits: 0xEA -> 0x0A
    applyStimulus(1'b0, 1'b0, 3'd2, 6'd0, 8'hEA);
    checkOutput("trunc_err", 64'(bus.o_err), 64'd0);
    checkOutput("trunc_rdidx", 64'(bus.o_rdidx), 64'h0A);

    // Error: chunk 1 lies beyond the 5-bit rdidx
    applyStimulus(1'b0, 1'b0, 3'd2, 6'd1, 8'h03);
    checkOutput("oor_err", 64'(bus.o_err), 64'd1);
    checkOutput("oor_rdidx", 64'(bus.o_rdidx), 64'h0A);

    applyStimulus(1'b0, 1'b1, 3'd5, 6'd0, 8'h99);
    checkOutput("err_pkt_err", 64'(bus.o_err), 64'd0);
    checkOutput("err_pkt_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("err_pkt_imm", 64'(bus.o_imm), 64'h99);
    checkOutput("err_pkt_rdidx", 64'(bus.o_rdidx), 64'h0A);
    checkOutput("err_pkt_seen", 64'(bus.o_seen), 64'b100100);
`ifdef SP2INS_ERRCNT_EN
    checkOutput("errcnt_3", 64'(bus.o_err_cnt), 64'd3);
`endif
    popRecord();

    // Mid-packet sof restarts the record
    applyStimulus(1'b1, 1'b0, 3'd0, 6'd0, 8'h11);
    applyStimulus(1'b0, 1'b0, 3'd0, 6'd1, 8'h22);
    checkOutput("midsof_rs1_pre", 64'(bus.o_rs1), 64'h2211);
    applyStimulus(1'b1, 1'b1, 3'd1, 6'd0, 8'hAA);
    checkOutput("midsof_err", 64'(bus.o_err), 64'd1);
    checkOutput("midsof_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("midsof_rs1", 64'(bus.o_rs1), 64'd0);
    checkOutput("midsof_rs2", 64'(bus.o_rs2), 64'hAA);
    checkOutput("midsof_seen", 64'(bus.o_seen), 64'b000010);
`ifdef SP2INS_ERRCNT_EN
    checkOutput("errcnt_4", 64'(bus.o_err_cnt), 64'd4);
`endif
    popRecord();

    // Async reset in COLLECT
    applyStimulus(1'b1, 1'b0, 3'd3, 6'd0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 3'd4, 6'd0, 8'h77);
    checkOutput("ar_pre_info", 64'(bus.o_info), 64'h5A);
    checkOutput("ar_pre_seen", 64'(bus.o_seen), 64'b011000);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("ar_seen", 64'(bus.o_seen), 64'd0);
    checkOutput("ar_info", 64'(bus.o_info), 64'd0);
    checkOutput("ar_pc", 64'(bus.o_pc), 64'd0);
    checkOutput("ar_ready", 64'(bus.i_sp_ready), 64'd1);
`ifdef SP2INS_ERRCNT_EN
    checkOutput("ar_errcnt", 64'(bus.o_err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ar_after_valid", 64'(bus.o_valid), 64'd0);

    applyStimulus(1'b1, 1'b0, 3'd5, 6'd0, 8'hEF);
    applyStimulus(1'b0, 1'b0, 3'd5, 6'd1, 8'hBE);
    applyStimulus(1'b0, 1'b0, 3'd5, 6'd2, 8'hAD);
    applyStimulus(1'b0, 1'b1, 3'd5, 6'd3, 8'hDE);
    checkOutput("fresh_valid", 64'(bus.o_valid), 64'd1);
    checkOutput("fresh_imm", 64'(bus.o_imm), 64'hDEADBEEF);
    checkOutput("fresh_seen", 64'(bus.o_seen), 64'b100000);
    checkOutput("fresh_info", 64'(bus.o_info), 64'd0);
    popRecord();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
